lsu_mem_req: RTL

- Load/store unit front end: the initiator side of the data-memory port.
- Accepts tagged load/store requests from the issue stage into an in-order request FIFO.
- Drives address, write data and the write/read strobes toward the memory stage's data memory.
- Returns load results with their tag on a valid/ready result port feeding the common data bus.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_fifo.sv | 40 ++++
 rtl/lsu_mem_req.sv | 98 +++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and widths for the load/store unit front end.
package lsu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int REQ_TAG_W = 3;
  typedef struct packed {
    logic                 is_store;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [REQ_TAG_W-1:0] tag;
  } lsu_req_t;
  typedef enum logic [1:0] {IDLE, LD_WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_fifo.sv
// lsu_fifo: in-order request FIFO of lsu_req_t with synchronous clear.
module lsu_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  lsu_req_t din,
  output logic     full,
  output logic     empty,
  output lsu_req_t head
);
  localparam int PW = $clog2(DEPTH);
  lsu_req_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/lsu_mem_req.sv
// lsu_mem_req: in-order load/store issue to data memory with tagged load results.
// Optional LSU_STATS_EN adds saturating ld_count/st_count strobe counters.
module lsu_mem_req
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
`ifdef LSU_STATS_EN
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              st_done,
  output logic [TAG_W-1:0]  st_done_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_data
);
  lsu_state_t state;
  lsu_req_t head, din;
  logic full, empty, issue;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign din = '{is_store: req_is_store, addr: req_addr, wdata: req_wdata, tag: REQ_TAG_W'(req_tag)};
  assign req_ready = !full && !flush;
  assign issue = state == IDLE && !empty;
  assign mem_wr = issue && head.is_store;
  assign mem_rd = issue && !head.is_store;
  assign st_done = mem_wr;
  assign st_done_tag = mem_wr ? TAG_W'(head.tag) : '0;
  assign mem_addr = issue ? head.addr : addr_q;
  assign mem_wdata = issue ? head.wdata : wdata_q;
  assign res_valid = state == RESP;
  lsu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .pop   (issue),
    .clear (flush),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  // A store strobed in a flush cycle still completes; flush only aborts load tracking.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      res_data <= '0;
      res_tag <= '0;
    end else begin
      if (issue) begin
        addr_q <= head.addr;
        wdata_q <= head.wdata;
      end
      if (flush) state <= IDLE;
      else
        case (state)
          IDLE: if (mem_rd) begin
            res_tag <= TAG_W'(head.tag);
            state <= LD_WAIT;
          end
          LD_WAIT: begin
            res_data <= mem_rdata;
            state <= RESP;
          end
          RESP: if (res_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
`ifdef LSU_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ld_count <= '0;
      st_count <= '0;
    end else begin
      ld_count <= ld_count + 16'(mem_rd && ~&ld_count);
      st_count <= st_count + 16'(mem_wr && ~&st_count);
    end
`endif
endmodule
